// File: rtl/port_page_packer.sv
// Per-port ingress stage: parses sop/header/payload/eop, packs 16-bit beats into
// 128-bit pages and queues them in a first-word-fall-through page FIFO.
module port_page_packer #(
   parameter int unsigned PAGE_FIFO_DEPTH = 4,
   parameter int unsigned AF_MARGIN       = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_sop,
   input  logic         wr_eop,
   input  logic         wr_vld,
   input  logic [15:0]  wr_data,
   output logic         full,
   output logic         almost_full,
   output logic         pg_vld,
   input  logic         pg_rdy,
   output logic [127:0] pg_data,
   output logic [3:0]   pg_words,
   output logic         pg_first,
   output logic         pg_last,
   output logic [3:0]   pg_dest,
   output logic [2:0]   pg_prior,
   output logic         proto_err,
   output logic         ovf_err
);

   localparam int unsigned PtrW = $clog2(PAGE_FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

   typedef struct packed {
      logic [127:0] data;
      logic [3:0]   words;
      logic         first;
      logic         last;
      logic [3:0]   dest;
      logic [2:0]   prior;
   } page_t;

   state_e       state_q, state_d;
   logic [127:0] buf_q, buf_d;
   logic [3:0]   wc_q, wc_d;
   logic [3:0]   dest_q, dest_d;
   logic [2:0]   prior_q, prior_d;
   logic         first_q, first_d;
   logic         proto_err_q, proto_err_d;
   logic         ovf_err_q, ovf_err_d;

   page_t           mem_q [PAGE_FIFO_DEPTH];
   page_t           mem_d [PAGE_FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            full_q, full_d;
   logic            af_q, af_d;

   logic  push_req;
   logic  push_last;
   page_t push_entry;
   logic  pop;
   logic  push_ok;
   page_t head;

   // Protocol parser and page assembly; at most one page push per cycle.
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      wc_d        = wc_q;
      dest_d      = dest_q;
      prior_d     = prior_q;
      first_d     = first_q;
      proto_err_d = proto_err_q;
      push_req    = 1'b0;
      push_last   = 1'b0;

      // A data beat coincident with a framing pulse is discarded.
      if (wr_vld && (wr_sop || wr_eop)) begin
         proto_err_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (wr_eop || wr_vld) begin
               proto_err_d = 1'b1;
            end
            if (wr_sop) begin
               state_d = StHead;
            end
         end

         StHead: begin
            if (wr_eop) begin
               proto_err_d = 1'b1;
               state_d     = StIdle;
            end
            if (wr_sop) begin
               state_d = StHead;
            end else if (wr_vld && !wr_eop) begin
               dest_d  = wr_data[3:0];
               prior_d = wr_data[6:4];
               first_d = 1'b1;
               buf_d   = '0;
               wc_d    = '0;
               state_d = StBody;
            end
         end

         StBody: begin
            if (wr_eop || wr_sop) begin
               // eop closes the packet first; a bare sop aborts it.
               if (wc_q != 4'd0) begin
                  push_req  = 1'b1;
                  push_last = 1'b1;
               end else if (wr_eop) begin
                  proto_err_d = 1'b1;
               end
               if (!wr_eop) begin
                  proto_err_d = 1'b1;
               end
               buf_d   = '0;
               wc_d    = '0;
               state_d = wr_sop ? StHead : StIdle;
            end else if (wr_vld) begin
               if (wc_q == 4'd8) begin
                  push_req  = 1'b1;
                  push_last = 1'b0;
                  buf_d     = {wr_data, 112'b0};
                  wc_d      = 4'd1;
               end else begin
                  for (int k = 0; k < 8; k++) begin
                     if (wc_q == 4'(k)) begin
                        buf_d[127-16*k -: 16] = wr_data;
                     end
                  end
                  wc_d = wc_q + 4'd1;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (push_req) begin
         first_d = 1'b0;
      end
   end

   always_comb begin
      push_entry.data  = buf_q;
      push_entry.words = wc_q;
      push_entry.first = first_q;
      push_entry.last  = push_last;
      push_entry.dest  = dest_q;
      push_entry.prior = prior_q;
   end

   // Page FIFO: a push into a full FIFO is accepted only alongside a pop.
   always_comb begin
      pop       = (count_q != '0) && pg_rdy;
      push_ok   = push_req && ((32'(count_q) != PAGE_FIFO_DEPTH) || pop);
      ovf_err_d = ovf_err_q | (push_req & ~push_ok);

      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_entry;
      end

      wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
      count_d  = count_q + CntW'(push_ok) - CntW'(pop);
      full_d   = (32'(count_d) == PAGE_FIFO_DEPTH);
      af_d     = ((PAGE_FIFO_DEPTH - 32'(count_d)) <= AF_MARGIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         buf_q       <= '0;
         wc_q        <= '0;
         dest_q      <= '0;
         prior_q     <= '0;
         first_q     <= 1'b0;
         proto_err_q <= 1'b0;
         ovf_err_q   <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         af_q        <= 1'b0;
         for (int i = 0; i < int'(PAGE_FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         wc_q        <= wc_d;
         dest_q      <= dest_d;
         prior_q     <= prior_d;
         first_q     <= first_d;
         proto_err_q <= proto_err_d;
         ovf_err_q   <= ovf_err_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         af_q        <= af_d;
         mem_q       <= mem_d;
      end
   end

   // Head fields are zeroed while the FIFO is empty so stale pages never show.
   always_comb begin
      head     = mem_q[rd_ptr_q];
      pg_vld   = (count_q != '0);
      pg_data  = pg_vld ? head.data  : '0;
      pg_words = pg_vld ? head.words : '0;
      pg_first = pg_vld & head.first;
      pg_last  = pg_vld & head.last;
      pg_dest  = pg_vld ? head.dest  : '0;
      pg_prior = pg_vld ? head.prior : '0;
   end

   assign full        = full_q;
   assign almost_full = af_q;
   assign proto_err   = proto_err_q;
   assign ovf_err     = ovf_err_q;

endmodule

// File: tb/tb_port_page_packer.sv
// Self-checking bench for port_page_packer: directed scenarios plus randomized
// packets compared against a page-level reference model.
module tb_port_page_packer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         wr_sop, wr_eop, wr_vld;
   logic [15:0]  wr_data;
   logic         full, almost_full, pg_vld, pg_rdy;
   logic [127:0] pg_data;
   logic [3:0]   pg_words;
   logic         pg_first, pg_last;
   logic [3:0]   pg_dest;
   logic [2:0]   pg_prior;
   logic         proto_err, ovf_err;

   typedef struct packed {
      logic [127:0] data;
      logic [3:0]   words;
      logic         first;
      logic         last;
      logic [3:0]   dest;
      logic [2:0]   prior;
   } page_t;

   page_t        cap_q[$];
   page_t        exp_q[$];
   logic [15:0]  pay_q[$];
   page_t        mon_p;
   int           checks   = 0;
   int           failures = 0;
   bit           rnd_rdy  = 1'b0;

   always #5 clk = ~clk;

   port_page_packer #(
      .PAGE_FIFO_DEPTH(4),
      .AF_MARGIN(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
      .full(full), .almost_full(almost_full),
      .pg_vld(pg_vld), .pg_rdy(pg_rdy), .pg_data(pg_data), .pg_words(pg_words),
      .pg_first(pg_first), .pg_last(pg_last), .pg_dest(pg_dest), .pg_prior(pg_prior),
      .proto_err(proto_err), .ovf_err(ovf_err)
   );

   // Every negedge with vld && rdy precedes exactly one pop at the next posedge.
   always @(negedge clk) begin
      if (rst_n && pg_vld && pg_rdy) begin
         mon_p = {pg_data, pg_words, pg_first, pg_last, pg_dest, pg_prior};
         cap_q.push_back(mon_p);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic drive(input logic s, input logic e, input logic v, input logic [15:0] d);
      wr_sop = s; wr_eop = e; wr_vld = v; wr_data = d;
      if (rnd_rdy) pg_rdy = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      wr_sop = 1'b0; wr_eop = 1'b0; wr_vld = 1'b0; wr_data = '0;
   endtask

   task automatic do_reset();
      wr_sop = 1'b0; wr_eop = 1'b0; wr_vld = 1'b0; wr_data = '0;
      pg_rdy = 1'b0; rnd_rdy = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic wait_room();
      int n = 0;
      while (full && n < 200) begin
         drive(1'b0, 1'b0, 1'b0, '0);
         n++;
      end
      if (full) begin
         checks++; failures++;
         $display("FAIL wait_room: full stuck at %0b, required 0", full);
      end
   endtask

   // Sends sop, header, pay_q beats, eop.
   task automatic send_pkt(input logic [15:0] hdr, input bit honour_full);
      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b1, hdr);
      foreach (pay_q[i]) begin
         if (honour_full) wait_room();
         drive(1'b0, 1'b0, 1'b1, pay_q[i]);
      end
      if (honour_full) wait_room();
      drive(1'b0, 1'b1, 1'b0, '0);
   endtask

   task automatic drain();
      int n = 0;
      rnd_rdy = 1'b0;
      pg_rdy  = 1'b1;
      while (pg_vld && n < 100) begin
         drive(1'b0, 1'b0, 1'b0, '0);
         n++;
      end
      if (pg_vld) begin
         checks++; failures++;
         $display("FAIL drain: pg_vld still %0b, required 0", pg_vld);
      end
   endtask

   // Reference: packet of n beats -> ceil(n/8) pages, last holds the remainder.
   task automatic model_pkt(input logic [15:0] hdr);
      int    n;
      int    np;
      int    w;
      page_t e;
      n  = pay_q.size();
      np = (n + 7) / 8;
      for (int p = 0; p < np; p++) begin
         e = '0;
         w = (n - 8 * p >= 8) ? 8 : n - 8 * p;
         for (int k = 0; k < w; k++) begin
            e.data = e.data | ({pay_q[8 * p + k], 112'b0} >> (16 * k));
         end
         e.words = 4'(w);
         e.first = (p == 0);
         e.last  = (p == np - 1);
         e.dest  = hdr[3:0];
         e.prior = hdr[6:4];
         exp_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      wr_sop = 1'b0; wr_eop = 1'b0; wr_vld = 1'b0; wr_data = '0; pg_rdy = 1'b0;
      #12;
      checks++;
      if ({full, almost_full, pg_vld, pg_data, pg_words, pg_first, pg_last, pg_dest, pg_prior}
          !== '0) begin
         failures++;
         $display("FAIL reset_outputs: full=%0b af=%0b vld=%0b data=%0h words=%0d, required all 0",
                  full, almost_full, pg_vld, pg_data, pg_words);
      end
      checks++;
      if ({proto_err, ovf_err} !== 2'b00) begin
         failures++;
         $display("FAIL reset_errs: got %b, required 00", {proto_err, ovf_err});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_20beat();
      int wexp [3] = '{8, 8, 4};
      do_reset();
      cap_q.delete();
      pay_q.delete();
      for (int i = 1; i <= 20; i++) pay_q.push_back(16'(i));
      pg_rdy = 1'b1;
      send_pkt(16'h0035, 1'b1);
      drain();
      checks++;
      if (cap_q.size() != 3) begin
         failures++;
         $display("FAIL p20_count: got %0d pages, required 3", cap_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({cap_q[i].words, cap_q[i].first, cap_q[i].last, cap_q[i].dest, cap_q[i].prior}
                !== {4'(wexp[i]), i == 0, i == 2, 4'd5, 3'd3}) begin
               failures++;
               $display("FAIL p20_page%0d: words=%0d first=%0b last=%0b dest=%0d prior=%0d, required %0d/%0b/%0b/5/3",
                        i, cap_q[i].words, cap_q[i].first, cap_q[i].last, cap_q[i].dest,
                        cap_q[i].prior, wexp[i], i == 0, i == 2);
            end
         end
         checks++;
         if (cap_q[0].data[127:112] !== 16'h0001) begin
            failures++;
            $display("FAIL p20_slot0: got %h, required 0001", cap_q[0].data[127:112]);
         end
         checks++;
         if (cap_q[2].data[79:64] !== 16'h0014 || cap_q[2].data[63:0] !== 64'h0) begin
            failures++;
            $display("FAIL p20_tail: got %h / %h, required 0014 / 0", cap_q[2].data[79:64],
                     cap_q[2].data[63:0]);
         end
      end
   endtask

   task automatic test_exact8();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b1, 16'h0049);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, 16'(16'hA0 + i));
      checks++;
      if (pg_vld !== 1'b0) begin
         failures++;
         $display("FAIL e8_hold: pg_vld=%0b after 8th beat, required 0", pg_vld);
      end
      drive(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if ({pg_vld, pg_words, pg_first, pg_last, pg_dest, pg_prior} !== {1'b1, 4'd8, 1'b1, 1'b1,
          4'd9, 3'd4}) begin
         failures++;
         $display("FAIL e8_page: vld=%0b words=%0d first=%0b last=%0b dest=%0d prior=%0d, required 1/8/1/1/9/4",
                  pg_vld, pg_words, pg_first, pg_last, pg_dest, pg_prior);
      end
      checks++;
      if (pg_data[15:0] !== 16'hA7 || pg_data[127:112] !== 16'hA0) begin
         failures++;
         $display("FAIL e8_data: got %h, required slot0=00a0 slot7=00a7", pg_data);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      cap_q.delete();
      for (int i = 0; i < 4; i++) begin
         pay_q.delete();
         pay_q.push_back(16'(i + 1));
         send_pkt(16'h0001, 1'b0);
         checks++;
         if ({almost_full, full} !== {i >= 2, i == 3}) begin
            failures++;
            $display("FAIL bp_level%0d: af=%0b full=%0b, required %0b/%0b", i, almost_full, full,
                     i >= 2, i == 3);
         end
      end
      pay_q.delete();
      pay_q.push_back(16'h0005);
      send_pkt(16'h0001, 1'b0);
      checks++;
      if ({ovf_err, full} !== 2'b11) begin
         failures++;
         $display("FAIL bp_ovf: ovf=%0b full=%0b, required 1/1", ovf_err, full);
      end
      pg_rdy = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0);
      pg_rdy = 1'b0;
      checks++;
      if ({full, almost_full} !== 2'b01) begin
         failures++;
         $display("FAIL bp_pop: full=%0b af=%0b, required 0/1", full, almost_full);
      end
      cap_q.delete();
      drain();
      checks++;
      if (cap_q.size() != 3) begin
         failures++;
         $display("FAIL bp_remaining: got %0d pages, required 3", cap_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (cap_q[k].data[127:112] !== 16'(k + 2)) begin
               failures++;
               $display("FAIL bp_order%0d: got %h, required %h", k, cap_q[k].data[127:112], k + 2);
            end
         end
      end
   endtask

   task automatic test_abort();
      do_reset();
      cap_q.delete();
      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b1, 16'h00A7);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 16'(16'h10 + i));
      pay_q.delete();
      pay_q.push_back(16'h0020);
      pay_q.push_back(16'h0021);
      send_pkt(16'h0012, 1'b0);
      drain();
      checks++;
      if (proto_err !== 1'b1) begin
         failures++;
         $display("FAIL abort_err: proto_err=%0b, required 1", proto_err);
      end
      checks++;
      if (cap_q.size() != 2) begin
         failures++;
         $display("FAIL abort_count: got %0d pages, required 2", cap_q.size());
      end else begin
         checks++;
         if ({cap_q[0].words, cap_q[0].first, cap_q[0].last, cap_q[0].dest, cap_q[0].prior,
              cap_q[0].data[127:80]} !== {4'd3, 1'b1, 1'b1, 4'd7, 3'd2, 48'h0010_0011_0012}) begin
            failures++;
            $display("FAIL abort_p0: got %h, required 3-word page dest 7 first/last", cap_q[0]);
         end
         checks++;
         if ({cap_q[1].words, cap_q[1].first, cap_q[1].last, cap_q[1].dest, cap_q[1].prior}
             !== {4'd2, 1'b1, 1'b1, 4'd2, 3'd1}) begin
            failures++;
            $display("FAIL abort_p1: words=%0d first=%0b last=%0b dest=%0d prior=%0d, required 2/1/1/2/1",
                     cap_q[1].words, cap_q[1].first, cap_q[1].last, cap_q[1].dest, cap_q[1].prior);
         end
      end
   endtask

   task automatic test_proto_err();
      for (int c = 0; c < 3; c++) begin
         do_reset();
         cap_q.delete();
         pg_rdy = 1'b1;
         if (c == 0) begin
            drive(1'b0, 1'b0, 1'b1, 16'h1234);
         end else if (c == 1) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            drive(1'b0, 1'b1, 1'b0, '0);
         end else begin
            drive(1'b1, 1'b0, 1'b0, '0);
            drive(1'b0, 1'b0, 1'b1, 16'h0033);
            drive(1'b0, 1'b1, 1'b0, '0);
         end
         repeat (3) drive(1'b0, 1'b0, 1'b0, '0);
         checks++;
         if ({proto_err, pg_vld, 32'(cap_q.size())} !== {1'b1, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL perr_case%0d: proto_err=%0b vld=%0b pages=%0d, required 1/0/0", c,
                     proto_err, pg_vld, cap_q.size());
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         pay_q.delete();
         pay_q.push_back(16'(16'h50 + i));
         send_pkt(16'h0004, 1'b0);
      end
      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b1, 16'h0004);
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 16'(16'h60 + i));
      rst_n = 1'b0;
      #1;
      checks++;
      if ({pg_vld, full} !== 2'b00) begin
         failures++;
         $display("FAIL rmid_async: vld=%0b full=%0b, required 0/0", pg_vld, full);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cap_q.delete();
      pg_rdy = 1'b1;
      pay_q.delete();
      pay_q.push_back(16'hBEEF);
      send_pkt(16'h0026, 1'b1);
      drain();
      checks++;
      if (cap_q.size() != 1) begin
         failures++;
         $display("FAIL rmid_count: got %0d pages, required 1", cap_q.size());
      end else begin
         checks++;
         if ({cap_q[0].words, cap_q[0].first, cap_q[0].last, cap_q[0].data} !==
             {4'd1, 1'b1, 1'b1, 16'hBEEF, 112'h0}) begin
            failures++;
            $display("FAIL rmid_page: words=%0d first=%0b last=%0b data=%h, required 1/1/1/beef..",
                     cap_q[0].words, cap_q[0].first, cap_q[0].last, cap_q[0].data);
         end
      end
   endtask

   task automatic test_random();
      int          len;
      logic [15:0] hdr;
      do_reset();
      cap_q.delete();
      exp_q.delete();
      rnd_rdy = 1'b1;
      for (int p = 0; p < 30; p++) begin
         len = $urandom_range(1, 24);
         if ($urandom_range(0, 3) == 0) len = 8 * $urandom_range(1, 3);
         hdr = 16'($urandom);
         pay_q.delete();
         for (int i = 0; i < len; i++) pay_q.push_back(16'($urandom));
         model_pkt(hdr);
         send_pkt(hdr, 1'b1);
         repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0, 1'b0, '0);
      end
      drain();
      checks++;
      if (cap_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL rnd_count: got %0d pages, required %0d", cap_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (cap_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL rnd_page%0d: got %h, required %h", i, cap_q[i], exp_q[i]);
            end
         end
      end
      checks++;
      if ({proto_err, ovf_err} !== 2'b00) begin
         failures++;
         $display("FAIL rnd_errs: got %b, required 00", {proto_err, ovf_err});
      end
   endtask

   initial begin
      test_reset();
      test_20beat();
      test_exact8();
      test_backpressure();
      test_abort();
      test_proto_err();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/port_page_packer.md
Name: port_page_packer

Overview:
- Per-port ingress stage that sits between one external write port and the controller's SRAM-write path.
- Parses the packet protocol (sop / header / payload / eop) and extracts destination port and priority from the header beat.
- Packs 16-bit payload beats into 128-bit pages, which is the ECC-encoder data width.
- Queues finished pages in a small FIFO with a valid/ready handshake and drives the port's full / almost_full backpressure.

Parameters:
- PAGE_FIFO_DEPTH, 4: number of 128-bit page entries in the output FIFO (power of two, >=2).
- AF_MARGIN, 1: almost_full asserts when free entries <= AF_MARGIN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_sop  in  1  single-cycle start-of-packet pulse; carries no data
- wr_eop  in  1  single-cycle end-of-packet pulse; carries no data
- wr_vld  in  1  wr_data valid this cycle
- wr_data  in  16  header or payload beat
- full  out  1  FIFO has no free entry
- almost_full  out  1  free entries <= AF_MARGIN
- pg_vld  out  1  FIFO head valid
- pg_rdy  in  1  consumer accepts the head page this cycle
- pg_data  out  128  page data; first beat in [127:112]
- pg_words  out  4  valid beats in page, 1..8, left-aligned
- pg_first  out  1  first page of the packet
- pg_last  out  1  last page of the packet
- pg_dest  out  4  destination port from the header
- pg_prior  out  3  priority from the header
- proto_err  out  1  sticky protocol-error flag; cleared only by reset
- ovf_err  out  1  sticky overflow flag; cleared only by reset

Behaviour:
- Reset, async on rst_n low: state IDLE, FIFO empty, assembly buffer cleared. All outputs 0: full, almost_full, pg_vld, pg_data, pg_words, pg_first, pg_last, pg_dest, pg_prior, proto_err, ovf_err.
- Header format: dest = wr_data[3:0], prior = wr_data[6:4]; bits [15:7] are ignored.
- FSM states: IDLE, HEAD, BODY.
  - IDLE: wr_sop goes to HEAD. wr_vld or wr_eop: beat ignored, proto_err set.
  - HEAD: first wr_vld latches dest/prior, goes to BODY; the header beat is not packed. wr_eop: proto_err set, go to IDLE, no page. wr_sop: stay in HEAD.
  - BODY: payload beats are packed (rules below). wr_eop: push assembly buffer with pg_last=1, go to IDLE; if zero payload beats were received, push nothing and set proto_err. wr_sop: flush any partial buffer as pg_last=1, set proto_err, go to HEAD.
- Packing:
  - Word count wc is 0..8. A beat with wc<8 is placed at slot wc, where slot k = bits [127-16k -: 16]; wc increments.
  - A beat arriving with wc==8 first pushes the full buffer (pg_last=0), then starts a new buffer with that beat at slot 0, wc=1.
  - Consequence: a full page is held until the next beat or eop decides pg_last. A packet of exactly 8N beats ends with an 8-word page carrying pg_last=1.
  - Unused slots are zero.
  - pg_first=1 on the first push of each packet.
  - pg_dest/pg_prior are copied per page from the header latched for that packet.
- wr_sop and wr_eop asserted in the same cycle: eop is processed first, then sop. In BODY the packet closes normally and the FSM enters HEAD.
- wr_vld coincident with wr_sop or wr_eop: the data beat is discarded and proto_err is set.
- FIFO:
  - First-word-fall-through. A push at clock edge T makes pg_vld=1 immediately after T if the FIFO was empty.
  - Pop occurs when pg_vld && pg_rdy.
  - Push and pop in the same cycle keep the occupancy count; this is legal even when the FIFO is full.
  - A push attempted while count==DEPTH and no pop occurs: page dropped, ovf_err set, FSM state unaffected.
  - full and almost_full are registered and reflect the post-edge count.
  - Upstream must stop driving wr_vld when full=1.
- Pointers wrap modulo PAGE_FIFO_DEPTH. Count width is clog2(DEPTH)+1.
- pg_* outputs hold their value while pg_vld=1 && pg_rdy=0.
- Reset asserted mid-packet: the partial page is discarded and queued pages are lost.

Test Plan:
- 20-beat packet:
  - Stimulus: sop, header 0x0035, payload 0x0001..0x0014, eop, pg_rdy=1.
  - Required: 3 pages with dest=5, prior=3.
  - Words 8/8/4. first=1,0,0; last=0,0,1.
  - Page 0 pg_data[127:112]=0x0001; page 2 pg_data[79:64]=0x0014, lower 64 bits zero.
- Exact 8-beat packet:
  - Required: one page, pg_words=8, first=1 and last=1.
  - The push occurs on the eop cycle, not on the 8th beat.
- Backpressure:
  - Stimulus: pg_rdy=0 while four 1-beat packets are sent.
  - Required: almost_full=1 after the 3rd push, full=1 after the 4th.
  - A 5th packet sent regardless is dropped and sets ovf_err=1.
  - Raising pg_rdy for one cycle clears full, and the entry count stays 4-1=3.
- Abort:
  - Stimulus: sop, header, 3 beats, then sop, header 0x0012, 2 beats, eop.
  - Required: a 3-word page with last=1 and proto_err=1, then a 2-word page with dest=2, prior=1, first=last=1.
- Protocol errors:
  - wr_vld in IDLE, eop in HEAD, header-only packet.
  - Required: no pages pushed and proto_err=1 for each case.
- Reset mid-packet:
  - Stimulus: rst_n low for 1 cycle after 5 payload beats, with 2 pages queued.
  - Required: pg_vld=0, full=0, and the next clean 1-beat packet yields a page with first=last=1, pg_words=1.
